ls_sub_unit_arbiter: RTL and testbench

- Sits between the load/store queue head (transaction_out/transaction_ready/accepted) and the memory sub-units (local mem, dcache, bus bridge).
- Decodes each head transaction's address to one sub-unit and issues it there.
- Tracks outstanding loads in order, serialising sub-unit switches so load data always returns in program order.
- Returns load data with its ID to writeback.

---
 rtl/ls_sub_unit_arbiter_pkg.sv | 35 +++
 rtl/ls_sub_unit_arbiter_fifo.sv | 49 ++++
 rtl/ls_sub_unit_arbiter.sv | 179 +++++++++++++++++
 tb/tb_ls_sub_unit_arbiter.sv | 360 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ls_sub_unit_arbiter_pkg.sv
// rtl/ls_sub_unit_arbiter_pkg.sv - shared types and sizing for the load/store sub-unit arbiter
package ls_sub_unit_arbiter_pkg;

    localparam int NUM_SUB_UNITS   = 3;
    localparam int MAX_OUTSTANDING = 4;
    localparam int ID_W            = 4;
    localparam int SUB_UNIT_SEL_W  = (NUM_SUB_UNITS > 1) ? $clog2(NUM_SUB_UNITS) : 1;

    typedef logic [ID_W-1:0]           id_t;
    typedef logic [SUB_UNIT_SEL_W-1:0] sub_unit_sel_t;

    typedef enum logic [1:0] {
        ARB_IDLE,
        ARB_ACTIVE,
        ARB_DRAIN
    } ls_arb_state_t;

    typedef struct packed {
        id_t           id;
        sub_unit_sel_t unit;
    } ls_outstanding_t;

    // Lowest-indexed hit wins when address windows overlap.
    function automatic sub_unit_sel_t lowest_hit(input logic [NUM_SUB_UNITS-1:0] hit);
        sub_unit_sel_t sel;
        sel = '0;
        for (int i = NUM_SUB_UNITS - 1; i >= 0; i--) begin
            if (hit[i]) begin
                sel = sub_unit_sel_t'(i);
            end
        end
        return sel;
    endfunction

endpackage

// File: rtl/ls_sub_unit_arbiter_fifo.sv
// rtl/ls_sub_unit_arbiter_fifo.sv - in-order tracker of outstanding loads and their target sub-unit
module ls_sub_unit_arbiter_fifo
    import ls_sub_unit_arbiter_pkg::*;
#(
    parameter int DEPTH = MAX_OUTSTANDING
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     i_push,
    input  logic                     i_pop,
    input  ls_outstanding_t          i_data,
    output ls_outstanding_t          o_data,
    output logic [$clog2(DEPTH):0]   o_count
);

    localparam int PTR_W = $clog2(DEPTH);

    ls_outstanding_t  r_mem [DEPTH];
    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [PTR_W:0]   r_count;

    // Callers never push when full or pop when empty; DEPTH is a power of two so pointers wrap naturally.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (i_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (i_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            r_count <= r_count + {{PTR_W{1'b0}}, i_push} - {{PTR_W{1'b0}}, i_pop};
        end
    end

    always_ff @(posedge clk) begin
        if (i_push) begin
            r_mem[r_wr_ptr] <= i_data;
        end
    end

    assign o_data  = r_mem[r_rd_ptr];
    assign o_count = r_count;

endmodule

// File: rtl/ls_sub_unit_arbiter.sv
// rtl/ls_sub_unit_arbiter.sv - issues LSQ head transactions to memory sub-units, returns load data in program order
module ls_sub_unit_arbiter
    import ls_sub_unit_arbiter_pkg::*;
#(
    parameter logic [NUM_SUB_UNITS*32-1:0] SUB_UNIT_BASE = {32'h0000_0000, 32'h6000_0000, 32'h8000_0000},
    parameter logic [NUM_SUB_UNITS*32-1:0] SUB_UNIT_MASK = {32'hF000_0000, 32'hF000_0000, 32'hF000_0000}
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        gc_issue_flush,
    input  logic                        txn_valid,
    input  logic [31:0]                 txn_addr,
    input  logic                        txn_load,
    input  logic                        txn_store,
    input  id_t                         txn_id,
    output logic                        txn_accepted,
    output logic [NUM_SUB_UNITS-1:0]    unit_req,
    input  logic [NUM_SUB_UNITS-1:0]    unit_ready,
    input  logic [NUM_SUB_UNITS-1:0]    unit_data_valid,
    input  logic [NUM_SUB_UNITS*32-1:0] unit_data,
    output logic                        resp_valid,
    output logic [31:0]                 resp_data,
    output id_t                         resp_id,
    output logic                        unmapped_err,
    output id_t                         unmapped_id,
    output logic                        protocol_err,
    output logic                        busy
);

    localparam int CNT_W = $clog2(MAX_OUTSTANDING) + 1;

    logic [NUM_SUB_UNITS-1:0] w_hit;
    logic                     w_any_hit;
    sub_unit_sel_t            w_sel;
    logic                     w_head_valid;
    logic                     w_unit_ok;
    logic                     w_fifo_full;
    logic                     w_issue;
    logic                     w_unmapped;
    logic                     w_push;
    logic                     w_pop;
    logic                     w_switch;
    logic [NUM_SUB_UNITS-1:0] w_stray;
    logic [CNT_W-1:0]         w_count;
    logic [CNT_W-1:0]         w_next_count;
    ls_outstanding_t          w_head;
    ls_outstanding_t          w_new_entry;
    logic [31:0]              w_head_data;

    ls_arb_state_t            r_state;
    sub_unit_sel_t            r_cur_unit;
    logic                     r_resp_valid;
    logic [31:0]              r_resp_data;
    id_t                      r_resp_id;
    logic                     r_unmapped_err;
    id_t                      r_unmapped_id;
    logic                     r_protocol_err;

    always_comb begin
        w_hit = '0;
        for (int i = 0; i < NUM_SUB_UNITS; i++) begin
            w_hit[i] = (txn_addr & SUB_UNIT_MASK[i*32 +: 32]) == SUB_UNIT_BASE[i*32 +: 32];
        end
    end

    assign w_any_hit = |w_hit;
    assign w_sel     = lowest_hit(w_hit);

    // A head that is neither load nor store is not a memory operation and is left alone.
    assign w_head_valid = rst_n & txn_valid & ~gc_issue_flush & (txn_load | txn_store);

    // Only one sub-unit may hold outstanding loads, so responses can never overtake each other.
    assign w_unit_ok   = (r_state == ARB_IDLE) | (w_sel == r_cur_unit);
    assign w_fifo_full = (w_count == CNT_W'(MAX_OUTSTANDING));
    assign w_issue     = w_head_valid & w_any_hit & unit_ready[w_sel] & w_unit_ok
                       & ~(txn_load & w_fifo_full);
    assign w_unmapped  = w_head_valid & ~w_any_hit;
    assign w_push      = w_issue & txn_load;
    assign w_switch    = txn_valid & w_any_hit & (w_sel != r_cur_unit);

    assign txn_accepted = w_issue | w_unmapped;

    always_comb begin
        unit_req = '0;
        if (w_issue) begin
            unit_req[w_sel] = 1'b1;
        end
    end

    assign w_new_entry = '{id: txn_id, unit: w_sel};

    ls_sub_unit_arbiter_fifo #(
        .DEPTH (MAX_OUTSTANDING)
    ) u_outstanding (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_push  (w_push),
        .i_pop   (w_pop),
        .i_data  (w_new_entry),
        .o_data  (w_head),
        .o_count (w_count)
    );

    assign w_pop        = (w_count != '0) & unit_data_valid[w_head.unit];
    assign w_head_data  = unit_data[32*w_head.unit +: 32];
    assign w_next_count = w_count + CNT_W'(w_push) - CNT_W'(w_pop);

    // Any return strobe that is not the oldest outstanding load's unit is a protocol violation.
    always_comb begin
        w_stray = unit_data_valid;
        if (w_count != '0) begin
            w_stray[w_head.unit] = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state        <= ARB_IDLE;
            r_cur_unit     <= '0;
            r_resp_valid   <= 1'b0;
            r_resp_data    <= '0;
            r_resp_id      <= '0;
            r_unmapped_err <= 1'b0;
            r_unmapped_id  <= '0;
            r_protocol_err <= 1'b0;
        end else begin
            if (w_issue) begin
                r_cur_unit <= w_sel;
            end

            r_resp_valid <= w_pop;
            if (w_pop) begin
                r_resp_data <= w_head_data;
                r_resp_id   <= w_head.id;
            end

            r_unmapped_err <= w_unmapped;
            if (w_unmapped) begin
                r_unmapped_id <= txn_id;
            end

            if (|w_stray) begin
                r_protocol_err <= 1'b1;
            end

            case (r_state)
                ARB_IDLE: begin
                    if (w_push) begin
                        r_state <= ARB_ACTIVE;
                    end
                end
                ARB_ACTIVE: begin
                    if (w_next_count == '0) begin
                        r_state <= ARB_IDLE;
                    end else if (w_switch) begin
                        r_state <= ARB_DRAIN;
                    end
                end
                ARB_DRAIN: begin
                    if (w_next_count == '0) begin
                        r_state <= ARB_IDLE;
                    end else if (w_issue) begin
                        r_state <= ARB_ACTIVE;
                    end
                end
                default: r_state <= ARB_IDLE;
            endcase
        end
    end

    assign resp_valid   = r_resp_valid;
    assign resp_data    = r_resp_data;
    assign resp_id      = r_resp_id;
    assign unmapped_err = r_unmapped_err;
    assign unmapped_id  = r_unmapped_id;
    assign protocol_err = r_protocol_err;
    assign busy         = (w_count != '0);

endmodule

// File: tb/tb_ls_sub_unit_arbiter.sv
// tb/tb_ls_sub_unit_arbiter.sv - directed self-checking bench with an in-order queue model of the arbiter
module tb_ls_sub_unit_arbiter;
    import ls_sub_unit_arbiter_pkg::*;

    logic                        clk;
    logic                        rst_n;
    logic                        gc_issue_flush;
    logic                        txn_valid;
    logic [31:0]                 txn_addr;
    logic                        txn_load;
    logic                        txn_store;
    id_t                         txn_id;
    logic                        txn_accepted;
    logic [NUM_SUB_UNITS-1:0]    unit_req;
    logic [NUM_SUB_UNITS-1:0]    unit_ready;
    logic [NUM_SUB_UNITS-1:0]    unit_data_valid;
    logic [NUM_SUB_UNITS*32-1:0] unit_data;
    logic                        resp_valid;
    logic [31:0]                 resp_data;
    id_t                         resp_id;
    logic                        unmapped_err;
    id_t                         unmapped_id;
    logic                        protocol_err;
    logic                        busy;

    int n_checks = 0;
    int n_errors = 0;

    ls_sub_unit_arbiter dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .gc_issue_flush  (gc_issue_flush),
        .txn_valid       (txn_valid),
        .txn_addr        (txn_addr),
        .txn_load        (txn_load),
        .txn_store       (txn_store),
        .txn_id          (txn_id),
        .txn_accepted    (txn_accepted),
        .unit_req        (unit_req),
        .unit_ready      (unit_ready),
        .unit_data_valid (unit_data_valid),
        .unit_data       (unit_data),
        .resp_valid      (resp_valid),
        .resp_data       (resp_data),
        .resp_id         (resp_id),
        .unmapped_err    (unmapped_err),
        .unmapped_id     (unmapped_id),
        .protocol_err    (protocol_err),
        .busy            (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Address map from the sub-unit windows: 0x8xxx_xxxx, 0x6xxx_xxxx, 0x0xxx_xxxx.
    function automatic int decode(input logic [31:0] a);
        case (a[31:28])
            4'h8:    return 0;
            4'h6:    return 1;
            4'h0:    return 2;
            default: return -1;
        endcase
    endfunction

    typedef struct {
        id_t id;
        int  unit;
    } ent_t;

    ent_t        q[$];
    int          last_unit = 0;
    bit          mdl_on = 0;
    bit          m_rv = 0;
    logic [31:0] m_rd = '0;
    id_t         m_rid = '0;
    bit          m_ue = 0;
    id_t         m_uid = '0;
    bit          m_perr = 0;

    always @(negedge clk) begin
        int                       sel;
        bit                       head_ok;
        bit                       exp_issue;
        bit                       exp_unm;
        bit                       pop;
        logic [NUM_SUB_UNITS-1:0] exp_req;
        logic [NUM_SUB_UNITS-1:0] stray;

        sel       = decode(txn_addr);
        head_ok   = rst_n && txn_valid && !gc_issue_flush && (txn_load || txn_store);
        exp_unm   = head_ok && (sel < 0);
        exp_issue = head_ok && (sel >= 0) && unit_ready[sel]
                    && (q.size() == 0 || sel == last_unit)
                    && !(txn_load && q.size() == MAX_OUTSTANDING);
        exp_req = '0;
        if (exp_issue) exp_req[sel] = 1'b1;

        if (mdl_on) begin
            chk("mdl_accepted", txn_accepted, exp_issue || exp_unm);
            chk("mdl_unit_req", unit_req, exp_req);
            chk("mdl_resp_valid", resp_valid, m_rv);
            if (m_rv) begin
                chk("mdl_resp_data", resp_data, m_rd);
                chk("mdl_resp_id", resp_id, m_rid);
            end
            chk("mdl_unmapped_err", unmapped_err, m_ue);
            if (m_ue) chk("mdl_unmapped_id", unmapped_id, m_uid);
            chk("mdl_protocol_err", protocol_err, m_perr);
            chk("mdl_busy", busy, q.size() != 0);
        end

        if (!rst_n) begin
            q.delete();
            last_unit = 0;
            m_rv      = 0;
            m_ue      = 0;
            m_perr    = 0;
            mdl_on    = 1;
        end else begin
            pop   = (q.size() > 0) && unit_data_valid[q[0].unit];
            stray = unit_data_valid;
            if (q.size() > 0) stray[q[0].unit] = 1'b0;
            m_rv = pop;
            if (pop) begin
                m_rd  = unit_data[q[0].unit*32 +: 32];
                m_rid = q[0].id;
                void'(q.pop_front());
            end
            if (exp_issue && txn_load) q.push_back('{id: txn_id, unit: sel});
            if (exp_issue) last_unit = sel;
            m_ue = exp_unm;
            if (exp_unm) m_uid = txn_id;
            if (|stray) m_perr = 1;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic head(input logic [31:0] a, input bit ld, input id_t id);
        txn_valid = 1'b1;
        txn_addr  = a;
        txn_load  = ld;
        txn_store = !ld;
        txn_id    = id;
    endtask

    task automatic nohead();
        txn_valid = 1'b0;
        txn_load  = 1'b0;
        txn_store = 1'b0;
    endtask

    task automatic ret(input int u, input logic [31:0] d);
        unit_data_valid    = '0;
        unit_data_valid[u] = 1'b1;
        unit_data[u*32 +: 32] = d;
    endtask

    task automatic noret();
        unit_data_valid = '0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not reach the end");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n           = 1'b0;
        gc_issue_flush  = 1'b0;
        txn_valid       = 1'b0;
        txn_addr        = '0;
        txn_load        = 1'b0;
        txn_store       = 1'b0;
        txn_id          = '0;
        unit_ready      = '1;
        unit_data_valid = '0;
        unit_data       = '0;

        repeat (3) tick();
        rst_n = 1'b1;
        #1;
        chk("rst_busy", busy, 0);
        chk("rst_resp_valid", resp_valid, 0);
        chk("rst_protocol_err", protocol_err, 0);
        chk("rst_unmapped_err", unmapped_err, 0);

        // Single load to unit0, held off one cycle by unit_ready.
        head(32'h8000_0010, 1, 4'd1);
        unit_ready = 3'b110;
        #1;
        chk("not_ready_accept", txn_accepted, 0);
        tick();
        unit_ready = 3'b111;
        #1;
        chk("load0_accept", txn_accepted, 1);
        chk("load0_req", unit_req, 3'b001);
        tick();
        nohead();
        #1;
        chk("load0_busy", busy, 1);
        tick();
        ret(0, 32'hDEAD_BEEF);
        tick();
        noret();
        #1;
        chk("load0_resp_valid", resp_valid, 1);
        chk("load0_resp_data", resp_data, 32'hDEAD_BEEF);
        chk("load0_resp_id", resp_id, 4'd1);
        chk("load0_busy_fall", busy, 0);

        // Fill the tracker with four unit1 loads; the fifth must wait for a pop.
        tick();
        for (int k = 0; k < 4; k++) begin
            head(32'h6000_0000 + 32'(k*4), 1, id_t'(4 + k));
            #1;
            chk("fill_accept", txn_accepted, 1);
            tick();
        end
        head(32'h6000_0010, 1, 4'd8);
        #1;
        chk("full_stall", txn_accepted, 0);
        tick();
        ret(1, 32'h1111_0004);
        #1;
        chk("full_no_bypass", txn_accepted, 0);
        tick();
        noret();
        #1;
        chk("full_after_pop", txn_accepted, 1);
        chk("full_first_resp_id", resp_id, 4'd4);
        tick();
        nohead();
        for (int k = 1; k <= 4; k++) begin
            ret(1, 32'h1111_0004 + 32'(k));
            tick();
        end
        noret();
        #1;
        chk("full_last_resp_id", resp_id, 4'd8);
        chk("full_last_resp_data", resp_data, 32'h1111_0008);
        chk("full_drained", busy, 0);

        // Sub-unit switch: unit2 load must wait until the unit0 load returns.
        tick();
        head(32'h8000_0100, 1, 4'd2);
        #1;
        chk("sw_first_accept", txn_accepted, 1);
        tick();
        head(32'h0000_0040, 1, 4'd3);
        #1;
        chk("sw_hold_req", unit_req, 3'b000);
        repeat (2) tick();
        ret(0, 32'hA5A5_0002);
        #1;
        chk("sw_pop_cycle_req", unit_req, 3'b000);
        tick();
        noret();
        #1;
        chk("sw_switch_req", unit_req, 3'b100);
        chk("sw_switch_accept", txn_accepted, 1);
        chk("sw_first_resp_id", resp_id, 4'd2);
        tick();
        nohead();
        ret(2, 32'hC3C3_0003);
        tick();
        noret();
        #1;
        chk("sw_second_resp_id", resp_id, 4'd3);
        chk("sw_second_resp_data", resp_data, 32'hC3C3_0003);

        // Unmapped store, then a flushed head.
        tick();
        head(32'hF000_0000, 0, 4'd9);
        #1;
        chk("unm_accept", txn_accepted, 1);
        chk("unm_req", unit_req, 3'b000);
        tick();
        nohead();
        #1;
        chk("unm_err", unmapped_err, 1);
        chk("unm_id", unmapped_id, 4'd9);
        tick();
        chk("unm_err_pulse", unmapped_err, 0);
        head(32'h8000_0000, 1, 4'd5);
        gc_issue_flush = 1'b1;
        #1;
        chk("flush_accept", txn_accepted, 0);
        tick();
        gc_issue_flush = 1'b0;
        nohead();

        // Stray return from unit2 while unit0 load is outstanding.
        tick();
        head(32'h8000_0200, 1, 4'd10);
        #1;
        chk("perr_load_accept", txn_accepted, 1);
        tick();
        nohead();
        ret(2, 32'hBAD0_BAD0);
        tick();
        noret();
        #1;
        chk("perr_set", protocol_err, 1);
        chk("perr_no_resp", resp_valid, 0);
        chk("perr_head_kept", busy, 1);
        ret(0, 32'h0B0B_000A);
        tick();
        noret();
        #1;
        chk("perr_resp_id", resp_id, 4'd10);
        chk("perr_resp_data", resp_data, 32'h0B0B_000A);
        chk("perr_sticky", protocol_err, 1);

        // Reset with three loads in flight, then issue to a different unit at once.
        tick();
        for (int k = 0; k < 3; k++) begin
            head(32'h8000_0300 + 32'(k*4), 1, id_t'(11 + k));
            tick();
        end
        nohead();
        #1;
        chk("pre_rst_busy", busy, 1);
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        #1;
        chk("mid_rst_busy", busy, 0);
        chk("mid_rst_resp_valid", resp_valid, 0);
        chk("mid_rst_perr", protocol_err, 0);
        head(32'h6000_0040, 1, 4'd14);
        #1;
        chk("post_rst_accept", txn_accepted, 1);
        chk("post_rst_req", unit_req, 3'b010);
        tick();
        nohead();
        ret(1, 32'h7777_000E);
        tick();
        noret();
        #1;
        chk("post_rst_resp_id", resp_id, 4'd14);
        tick();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
